// File: rtl/t_down_timer.sv
// t_down_timer: loadable down-counting timer.
// The count register is a row of T flip-flops joined by a borrow chain, so a
// decrement is just "toggle every bit up to and including the lowest 1".
// When the timer expires it emits a one-cycle terminal-count pulse. In
// one-shot mode it then stops at zero. In periodic mode it reloads the last
// loaded value.
//
// Handshake: none. Load, Clr and En are level inputs sampled on each rising
// Clk edge. Priority on that edge is Clr > Load > count step. Busy is the
// registered FSM state (1 = RUN) and doubles as the state debug view.
module t_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    input  logic             Reload,
    output logic [WIDTH-1:0] Q,
    output logic             Zero,
    output logic             Tc,
    output logic             Busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_tc;

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_dec;
    logic             w_q_is_one;

    // Borrow chain: bit i toggles only while every lower bit is 0.
    always_comb begin
        w_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_t[i] = w_t[i-1] & ~r_q[i-1];
        end
        w_dec      = r_q ^ w_t;
        w_q_is_one = (r_q == {{(WIDTH-1){1'b0}}, 1'b1});
    end

    // Timer FSM, count register, reload register and terminal-count pulse.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_q     <= '0;
            r_r     <= '0;
            r_tc    <= 1'b0;
            r_state <= S_IDLE;
        end else if (Load) begin
            // A load also wins over an expiry on the same edge, so no Tc.
            r_q     <= D;
            r_r     <= D;
            r_tc    <= 1'b0;
            r_state <= (D != '0) ? S_RUN : S_IDLE;
        end else if (r_state == S_RUN && En) begin
            if (w_q_is_one) begin
                r_tc <= 1'b1;
                if (Reload) begin
                    // Periodic mode jumps straight back to R, so 0 never shows.
                    r_q <= r_r;
                end else begin
                    r_q     <= '0;
                    r_state <= S_IDLE;
                end
            end else begin
                r_q  <= w_dec;
                r_tc <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign Tc   = r_tc;
    assign Busy = (r_state == S_RUN);
    assign Zero = (r_q == '0);

endmodule

// File: tb/tb_t_down_timer.sv
// Bench for t_down_timer: a directed vector table, then random traffic
// compared against an arithmetic model of the timer.
module tb_t_down_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             reload;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;
  logic             busy;

  int checks = 0;
  int errors = 0;

  t_down_timer #(.WIDTH(WIDTH)) dut (
    .Clk    (clk),
    .Clr    (clr),
    .Load   (load),
    .D      (d),
    .En     (en),
    .Reload (reload),
    .Q      (q),
    .Zero   (zero),
    .Tc     (tc),
    .Busy   (busy)
  );

  // Clock and input defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clr    = 1'b1;
    load   = 1'b0;
    d      = '0;
    en     = 1'b0;
    reload = 1'b0;
  end

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       rel;
    logic [3:0] d;
    int         exp_q;
    int         exp_tc;
    int         exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic l, input logic e,
                              input logic r, input int dv, input int eq,
                              input int etc, input int eb);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.rel = r; v.d = 4'(dv);
    v.exp_q = eq; v.exp_tc = etc; v.exp_busy = eb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive the inputs at the falling edge, then sample just after the rising edge.
  task automatic drive_cycle(input logic c, input logic l, input logic e,
                             input logic r, input logic [WIDTH-1:0] dv);
    @(negedge clk);
    clr = c; load = l; en = e; reload = r; d = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int eq, input int etc,
                               input int eb);
    check({tag, ".q"},    int'(q),    eq);
    check({tag, ".tc"},   int'(tc),   etc);
    check({tag, ".busy"}, int'(busy), eb);
    check({tag, ".zero"}, int'(zero), (eq == 0) ? 1 : 0);
  endtask

  // Model state: the timer in plain integer terms.
  int m_cnt, m_rel, m_tc;
  bit m_run;

  task automatic model_step(input logic c, input logic l, input logic e,
                            input logic r, input int dv);
    if (c) begin
      m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0;
    end else if (l) begin
      m_cnt = dv; m_rel = dv; m_run = (dv != 0); m_tc = 0;
    end else if (m_run && e) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (r) m_cnt = m_rel;
        else begin
          m_cnt = 0;
          m_run = 0;
        end
      end else begin
        m_cnt = m_cnt - 1;
        m_tc  = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  initial begin
    // Reset: Clr wins over Load and En.
    add(1, 1, 1, 0, 9, 0, 0, 0);
    add(1, 1, 1, 0, 9, 0, 0, 0);
    // One-shot from 5.
    add(0, 1, 0, 0, 5, 5, 0, 1);
    add(0, 0, 1, 0, 0, 4, 0, 1);
    add(0, 0, 1, 0, 0, 3, 0, 1);
    add(0, 0, 1, 0, 0, 2, 0, 1);
    add(0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 7, 0, 0, 0);
    // Periodic from 3.
    add(0, 1, 0, 1, 3, 3, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      add(0, 0, 1, 1, 0, 3 - ((k - 1) % 3 + 1) == 0 ? 3 : 3 - ((k - 1) % 3 + 1),
          (k % 3 == 0) ? 1 : 0, 1);
    end
    // Full-width borrow chain with gapped enable.
    add(0, 1, 0, 0, 15, 15, 0, 1);
    for (int v = 14; v >= 0; v--) begin
      add(0, 0, 1, 0, 0, v, (v == 0) ? 1 : 0, (v != 0) ? 1 : 0);
      add(0, 0, 0, 0, 0, v, 0, (v != 0) ? 1 : 0);
    end
    // Load collides with expiry.
    add(0, 1, 0, 0, 1, 1, 0, 1);
    add(0, 1, 1, 0, 6, 6, 0, 1);
    // Clr collides with load and expiry.
    add(0, 1, 0, 0, 1, 1, 0, 1);
    add(1, 1, 1, 0, 6, 0, 0, 0);
    // Periodic with R=1: Tc on every enabled edge.
    add(0, 1, 0, 1, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 1, 0, 1);
    // Reload sampled only at expiry: switch to one-shot at the last step.
    add(0, 1, 0, 1, 2, 2, 0, 1);
    add(0, 0, 1, 1, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    // Zero load stays idle.
    add(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].rel, vecs[i].d);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tc,
                    vecs[i].exp_busy);
    end

    // Random traffic against the model, starting from a clear.
    m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0;
    for (int i = 0; i < 600; i++) begin
      logic c, l, e, r;
      logic [WIDTH-1:0] dv;
      c  = (i == 0) || ($urandom_range(0, 40) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 1) != 0;
      dv = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      drive_cycle(c, l, e, r, dv);
      model_step(c, l, e, r, int'(dv));
      check_outputs($sformatf("rnd%0d", i), m_cnt, m_tc, m_run ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
